audio_pan_mixer: RTL and testbench

AUDIO_PAN_MIXER -- requirements
Module: audio_pan_mixer

---
 rtl/audio_mix_pkg.sv | 45 ++++
 rtl/sd_dac_1st.sv | 26 ++
 rtl/audio_pan_mixer.sv | 187 ++++++++++++++++++
 tb/tb_audio_pan_mixer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio pan mixer: weight codes, pan modes,
// fixed ABC/ACB weight tables and the mixer FSM state type.
package audio_mix_pkg;

    localparam logic [1:0] WeightOff     = 2'd0;
    localparam logic [1:0] WeightHalf    = 2'd1;
    localparam logic [1:0] WeightFull    = 2'd2;
    localparam logic [1:0] WeightFullAlt = 2'd3;

    typedef enum logic [1:0] {
        PanMono   = 2'b00,
        PanAbc    = 2'b01,
        PanAcb    = 2'b10,
        PanCustom = 2'b11
    } pan_mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAcc   = 2'd1,
        StScale = 2'd2,
        StOut   = 2'd3
    } mix_state_e;

    // Tables cover up to 8 channels; channel k lives at [2k+1:2k].
    localparam logic [15:0] AbcLeft = {WeightHalf, WeightHalf, WeightHalf, WeightHalf,
                                       WeightHalf, WeightOff, WeightHalf, WeightFull};
    localparam logic [15:0] AbcRight = {WeightHalf, WeightHalf, WeightHalf, WeightHalf,
                                        WeightHalf, WeightFull, WeightHalf, WeightOff};
    localparam logic [15:0] AcbLeft = {WeightHalf, WeightHalf, WeightHalf, WeightHalf,
                                       WeightHalf, WeightHalf, WeightOff, WeightFull};
    localparam logic [15:0] AcbRight = {WeightHalf, WeightHalf, WeightHalf, WeightHalf,
                                        WeightHalf, WeightHalf, WeightFull, WeightOff};

    // Multiplier in half-units: the accumulated sum is halved again at the scale step.
    function automatic logic [1:0] weight_mult(input logic [1:0] code);
        logic [1:0] mult;
        unique case (code)
            WeightOff:  mult = 2'd0;
            WeightHalf: mult = 2'd1;
            default:    mult = 2'd2;
        endcase
        return mult;
    endfunction

endpackage

// File: rtl/sd_dac_1st.sv
// First-order sigma-delta modulator: one-bit stream whose density is data_in / 2^W.
module sd_dac_1st #(
    parameter int unsigned W = 16
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    output logic         bit_out
);

    logic [W:0] acc_q;
    logic [W:0] sum;

    assign sum = {1'b0, acc_q[W-1:0]} + {1'b0, data_in};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q   <= '0;
            bit_out <= 1'b0;
        end else begin
            acc_q   <= sum;
            bit_out <= sum[W];
        end
    end

endmodule

// File: rtl/audio_pan_mixer.sv
// Multi-channel pan mixer: accumulates one weighted channel per cycle into left/right,
// scales and saturates, then drives a sigma-delta DAC per side.
module audio_pan_mixer
    import audio_mix_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                sample_stb,
    input  logic [NCH*IN_W-1:0] ch_in,
    input  logic [1:0]          pan_mode,
    input  logic [4*NCH-1:0]    pan_cfg,
    input  logic [2:0]          gain_shift,
    output logic [OUT_W-1:0]    out_l,
    output logic [OUT_W-1:0]    out_r,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun,
    output logic                dac_l,
    output logic                dac_r
);

    localparam int unsigned ACC_W  = IN_W + 2 + $clog2(NCH);
    localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SCL_W  = ACC_W + 6;
    localparam int unsigned WIDE_W = (SCL_W > OUT_W) ? SCL_W : OUT_W;
    localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

    mix_state_e state_q, state_d;
    logic accept, step, scale;

    logic [NCH*IN_W-1:0] ch_q;
    pan_mode_e           mode_q;
    logic [4*NCH-1:0]    cfg_q;
    logic [2:0]          shift_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ACC_W-1:0]    acc_l_q, acc_r_q;
    logic [ACC_W-1:0]    acc_l_d, acc_r_d;
    logic [OUT_W-1:0]    out_l_q, out_r_q;

    logic [IN_W-1:0]   cur_sample;
    logic [1:0]        code_l, code_r;
    logic [IN_W+1:0]   prod_l, prod_r;
    logic [WIDE_W-1:0] wide_l, wide_r;
    logic [OUT_W-1:0]  sat_l, sat_r;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        scale   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_stb) begin
                    accept  = 1'b1;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                step = 1'b1;
                if (idx_q == IDX_W'(NCH - 1)) begin
                    state_d = StScale;
                end
            end
            StScale: begin
                scale   = 1'b1;
                state_d = StOut;
            end
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot of the inputs so later changes cannot disturb a mix in flight.
    always_ff @(posedge clk_sys) begin
        if (accept) begin
            ch_q    <= ch_in;
            mode_q  <= pan_mode_e'(pan_mode);
            cfg_q   <= pan_cfg;
            shift_q <= gain_shift;
        end
    end

    always_comb begin
        cur_sample = '0;
        code_l     = WeightOff;
        code_r     = WeightOff;
        for (int k = 0; k < NCH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_sample = ch_q[k*IN_W +: IN_W];
                unique case (mode_q)
                    PanMono: begin
                        code_l = WeightFull;
                        code_r = WeightFull;
                    end
                    PanAbc: begin
                        code_l = AbcLeft[2*k +: 2];
                        code_r = AbcRight[2*k +: 2];
                    end
                    PanAcb: begin
                        code_l = AcbLeft[2*k +: 2];
                        code_r = AcbRight[2*k +: 2];
                    end
                    default: begin
                        code_l = cfg_q[4*k +: 2];
                        code_r = cfg_q[4*k+2 +: 2];
                    end
                endcase
            end
        end
    end

    always_comb begin
        prod_l  = (IN_W+2)'(cur_sample) * (IN_W+2)'(weight_mult(code_l));
        prod_r  = (IN_W+2)'(cur_sample) * (IN_W+2)'(weight_mult(code_r));
        acc_l_d = acc_l_q + ACC_W'(prod_l);
        acc_r_d = acc_r_q + ACC_W'(prod_r);
    end

    // Accumulator holds half-units, so drop one bit before applying the gain.
    always_comb begin
        wide_l = WIDE_W'(acc_l_q >> 1) << shift_q;
        wide_r = WIDE_W'(acc_r_q >> 1) << shift_q;
        sat_l  = (wide_l > WIDE_W'(OUT_MAX)) ? OUT_MAX : OUT_W'(wide_l);
        sat_r  = (wide_r > WIDE_W'(OUT_MAX)) ? OUT_MAX : OUT_W'(wide_r);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
            idx_q   <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
        end else begin
            if (accept) begin
                acc_l_q <= '0;
                acc_r_q <= '0;
                idx_q   <= '0;
            end else if (step) begin
                acc_l_q <= acc_l_d;
                acc_r_q <= acc_r_d;
                idx_q   <= idx_q + 1'b1;
            end
            if (scale) begin
                out_l_q <= sat_l;
                out_r_q <= sat_r;
            end
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign overrun   = sample_stb & busy & ~reset;

    sd_dac_1st #(
        .W(OUT_W)
    ) u_sd_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .data_in (out_l_q),
        .bit_out (dac_l)
    );

    sd_dac_1st #(
        .W(OUT_W)
    ) u_sd_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .data_in (out_r_q),
        .bit_out (dac_r)
    );

endmodule

// File: tb/tb_audio_pan_mixer.sv
// Bench for audio_pan_mixer: directed vectors with literal expectations plus a
// cycle-level behavioural model compared against the outputs every cycle.
module tb_audio_pan_mixer;

    localparam int NCH   = 3;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

    logic                clk_sys = 1'b0;
    logic                reset;
    logic                sample_stb;
    logic [NCH*IN_W-1:0] ch_in;
    logic [1:0]          pan_mode;
    logic [4*NCH-1:0]    pan_cfg;
    logic [2:0]          gain_shift;
    logic [OUT_W-1:0]    out_l, out_r;
    logic                out_valid, busy, overrun, dac_l, dac_r;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    audio_pan_mixer #(
        .NCH   (NCH),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .sample_stb (sample_stb),
        .ch_in      (ch_in),
        .pan_mode   (pan_mode),
        .pan_cfg    (pan_cfg),
        .gain_shift (gain_shift),
        .out_l      (out_l),
        .out_r      (out_r),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .dac_l      (dac_l),
        .dac_r      (dac_r)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Weight in half-units: off=0, half=1, full=2 (code 3 also full).
    function automatic int half_weight(input int mode, input int k, input logic [11:0] cfg,
                                       input bit right);
        int code;
        case (mode)
            0: code = 2;
            1: code = right ? ((k == 0) ? 0 : (k == 2) ? 2 : 1) : ((k == 0) ? 2 : (k == 2) ? 0 : 1);
            2: code = right ? ((k == 0) ? 0 : (k == 1) ? 2 : 1) : ((k == 0) ? 2 : (k == 1) ? 0 : 1);
            default: code = int'((cfg >> (4 * k + (right ? 2 : 0))) & 12'd3);
        endcase
        return (code == 3) ? 2 : code;
    endfunction

    function automatic int mix(input logic [23:0] ch, input int mode, input logic [11:0] cfg,
                               input int gs, input bit right);
        longint halves = 0;
        longint v;
        for (int k = 0; k < NCH; k++) begin
            halves += longint'(ch[8*k +: 8]) * half_weight(mode, k, cfg, right);
        end
        v = (halves / 2) * (longint'(1) << gs);
        if (v > 65535) v = 65535;
        return int'(v);
    endfunction

    // Cycle-level model: an accepted strobe makes the block busy for NCH+2 cycles,
    // with out_valid and new outputs on the last of them.
    int     m_cnt = 0;
    int     m_pend_l = 0, m_pend_r = 0;
    int     m_out_l = 0, m_out_r = 0;
    longint m_sd_l = 0, m_sd_r = 0;
    int     m_dac_l = 0, m_dac_r = 0;

    initial begin
        longint sum;
        forever begin
            @(negedge clk_sys);
            if (m_cnt == 1) begin
                m_out_l = m_pend_l;
                m_out_r = m_pend_r;
            end
            if (chk_en) begin
                check("model_out_valid", 32'(out_valid), 32'(m_cnt == 1));
                check("model_busy", 32'(busy), 32'(m_cnt != 0));
                check("model_overrun", 32'(overrun), 32'(sample_stb && m_cnt != 0 && !reset));
                check("model_out_l", 32'(out_l), m_out_l);
                check("model_out_r", 32'(out_r), m_out_r);
                check("model_dac_l", 32'(dac_l), m_dac_l);
                check("model_dac_r", 32'(dac_r), m_dac_r);
            end
            if (reset) begin
                m_cnt = 0; m_out_l = 0; m_out_r = 0;
                m_sd_l = 0; m_sd_r = 0; m_dac_l = 0; m_dac_r = 0;
            end else begin
                sum = (m_sd_l % 65536) + m_out_l;
                m_dac_l = (sum >= 65536) ? 1 : 0;
                m_sd_l = sum;
                sum = (m_sd_r % 65536) + m_out_r;
                m_dac_r = (sum >= 65536) ? 1 : 0;
                m_sd_r = sum;
                if (m_cnt > 0) begin
                    m_cnt--;
                end else if (sample_stb) begin
                    m_pend_l = mix(ch_in, int'(pan_mode), pan_cfg, int'(gain_shift), 1'b0);
                    m_pend_r = mix(ch_in, int'(pan_mode), pan_cfg, int'(gain_shift), 1'b1);
                    m_cnt = NCH + 2;
                end
            end
        end
    end

    // Strobe one mix, scramble the inputs while it runs, and wait for out_valid.
    task automatic run_mix(input logic [1:0] mode, input logic [23:0] ch, input logic [11:0] cfg,
                           input logic [2:0] gs, output int lat);
        pan_mode = mode; ch_in = ch; pan_cfg = cfg; gain_shift = gs;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        ch_in = ~ch; pan_mode = ~mode; pan_cfg = ~cfg; gain_shift = ~gs;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        tick();
    endtask

    task automatic strobe_pattern(input int a, input int b, input int n, output int ov_cnt,
                                  output int ov_cyc, output int v_cnt, output int v_cyc);
        ov_cnt = 0; ov_cyc = -1; v_cnt = 0; v_cyc = -1;
        for (int c = 0; c < n; c++) begin
            sample_stb = (c == a || c == b);
            #1;
            if (overrun) begin ov_cnt++; ov_cyc = c; end
            if (out_valid) begin v_cnt++; v_cyc = c; end
            tick();
        end
        sample_stb = 1'b0;
    endtask

    initial begin
        int lat, ov_cnt, ov_cyc, v_cnt, v_cyc, ones, flips, busy3, outl3;
        logic prev;
        reset = 1'b1; sample_stb = 1'b0; ch_in = '0; pan_mode = 2'b00;
        pan_cfg = '0; gain_shift = '0;
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        check("reset_out_l", 32'(out_l), 0);
        check("reset_out_r", 32'(out_r), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_dac", 32'({dac_l, dac_r}), 0);

        run_mix(2'b00, 24'hFFFFFF, 12'h000, 3'd6, lat);
        check("mono_latency", lat, 5);
        check("mono_g6_l", 32'(out_l), 32'h0000BF40);
        check("mono_g6_r", 32'(out_r), 32'h0000BF40);

        run_mix(2'b00, 24'hFFFFFF, 12'h000, 3'd7, lat);
        check("mono_g7_sat_l", 32'(out_l), 32'h0000FFFF);
        check("mono_g7_sat_r", 32'(out_r), 32'h0000FFFF);

        run_mix(2'b01, {8'd0, 8'd51, 8'd100}, 12'h000, 3'd0, lat);
        check("abc_l", 32'(out_l), 125);
        check("abc_r", 32'(out_r), 25);

        run_mix(2'b10, {8'd0, 8'd51, 8'd100}, 12'h000, 3'd0, lat);
        check("acb_l", 32'(out_l), 100);
        check("acb_r", 32'(out_r), 51);

        run_mix(2'b11, {8'd40, 8'd20, 8'd10}, 12'hD87, 3'd1, lat);
        check("custom_l", 32'(out_l), 60);
        check("custom_r", 32'(out_r), 130);

        pan_mode = 2'b01; ch_in = {8'd7, 8'd9, 8'd200}; gain_shift = 3'd2;
        strobe_pattern(0, 2, 10, ov_cnt, ov_cyc, v_cnt, v_cyc);
        check("ovr_count", ov_cnt, 1);
        check("ovr_cycle", ov_cyc, 2);
        check("ovr_valid_count", v_cnt, 1);
        check("ovr_valid_cycle", v_cyc, 5);

        strobe_pattern(0, 5, 12, ov_cnt, ov_cyc, v_cnt, v_cyc);
        check("out_cycle_ovr_cycle", ov_cyc, 5);
        check("out_cycle_valid_count", v_cnt, 1);

        // Reset two cycles into a mix.
        v_cnt = 0; busy3 = -1; outl3 = -1;
        for (int c = 0; c < 10; c++) begin
            sample_stb = (c == 0);
            reset = (c == 2);
            #1;
            if (out_valid) v_cnt++;
            if (c == 3) begin busy3 = int'(busy); outl3 = int'(out_l); end
            tick();
        end
        sample_stb = 1'b0; reset = 1'b0;
        check("abort_valid_count", v_cnt, 0);
        check("abort_busy", busy3, 0);
        check("abort_out_l", outl3, 0);

        run_mix(2'b00, 24'h008080, 12'h000, 3'd7, lat);
        check("dac_half_out_l", 32'(out_l), 32'h00008000);
        ones = 0; flips = 0; prev = dac_l;
        for (int c = 0; c < 1024; c++) begin
            if (dac_l) ones++;
            if (c > 0 && dac_l != prev) flips++;
            prev = dac_l;
            tick();
        end
        check("dac_half_ones", ones, 512);
        check("dac_half_alternates", flips, 1023);

        reset = 1'b1; tick(); reset = 1'b0;
        ones = 0;
        for (int c = 0; c < 64; c++) begin
            if (dac_l) ones++;
            tick();
        end
        check("dac_zero_ones", ones, 0);

        reset = 1'b1; sample_stb = 1'b1; ch_in = 24'hFFFFFF;
        tick();
        reset = 1'b0; sample_stb = 1'b0;
        check("reset_beats_stb_busy", 32'(busy), 0);
        repeat (8) tick();
        check("reset_beats_stb_out_l", 32'(out_l), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
